// File: rtl/paralelo_serial_serdes_pkg.sv
// serdes_pkg: shared word width and frame counter types for the serdes pair
package serdes_pkg;
    localparam int WIDTH = 10;
    localparam int CNT_W = $clog2(WIDTH);
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/paralelo_serial_serdes_if.sv
// paralelo_serial_serdes_if: parallel words in/out and the serial link of the serdes pair
interface paralelo_serial_serdes_if #(parameter int WIDTH = serdes_pkg::WIDTH);
    logic [WIDTH-1:0] entradas;
    logic             salida;
    logic             entrada;
    logic [WIDTH-1:0] salidas;
    logic             salidasValidas;
    modport master (output entradas, entrada, input salida, salidas, salidasValidas);
    modport slave  (input entradas, entrada, output salida, salidas, salidasValidas);
endinterface

// File: rtl/paralelo_serial_serdes_frame_counter.sv
// serdes_frame_counter: counts 0..N-1 and wraps, cleared synchronously by rst
module serdes_frame_counter import serdes_pkg::*; #(
    parameter int N = WIDTH,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/paralelo_serial_serdes.sv
// paralelo_serial_serdes: MSB-first word serializer and deserializer framed by a shared reset
module paralelo_serial_serdes #(
    parameter int WIDTH = serdes_pkg::WIDTH,
    localparam int CW = $clog2(WIDTH)
) (
    input logic                     clk,
    input logic                     rstContador,
    paralelo_serial_serdes_if.slave bus
);
    logic [CW-1:0] cnt_tx, cnt_rx;
    // transmitter: the word register shifts left so the next bit is always at the MSB
    logic [WIDTH-1:0] palabra_tx_q, palabra_tx_d;
    logic             salida_q, salida_d;
    serdes_frame_counter #(.N(WIDTH)) u_cnt_tx (.clk(clk), .rst(rstContador), .cnt(cnt_tx));
    always_comb begin
        salida_d     = (cnt_tx == '0) ? bus.entradas[WIDTH-1] : palabra_tx_q[WIDTH-1];
        palabra_tx_d = (cnt_tx == '0) ? {bus.entradas[WIDTH-2:0], 1'b0}
                                      : {palabra_tx_q[WIDTH-2:0], 1'b0};
    end
    always_ff @(posedge clk) begin
        if (rstContador) begin
            palabra_tx_q <= '0;
            salida_q     <= 1'b0;
        end else begin
            palabra_tx_q <= palabra_tx_d;
            salida_q     <= salida_d;
        end
    end
    assign bus.salida = salida_q;
    // receiver: the bit arriving on a frame-start edge is the last bit of the previous word
    logic [WIDTH-1:0] sh_q, sh_d, salidas_q, salidas_d;
    logic             valid_q, valid_d;
    serdes_frame_counter #(.N(WIDTH)) u_cnt_rx (.clk(clk), .rst(rstContador), .cnt(cnt_rx));
    always_comb begin
        sh_d      = {sh_q[WIDTH-2:0], bus.entrada};
        salidas_d = (cnt_rx == '0) ? sh_d : salidas_q;
        valid_d   = (cnt_rx == '0);
    end
    always_ff @(posedge clk) begin
        if (rstContador) begin
            sh_q      <= '0;
            salidas_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            salidas_q <= salidas_d;
            valid_q   <= valid_d;
        end
    end
    assign bus.salidas        = salidas_q;
    assign bus.salidasValidas = valid_q;
endmodule

// File: tb/tb_paralelo_serial_serdes.sv
// tb_paralelo_serial_serdes: loopback bench with a frame-level model and literal checkpoints
module tb_paralelo_serial_serdes;
    localparam int W = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    paralelo_serial_serdes_if #(.WIDTH(W)) bus ();
    assign bus.entrada = bus.salida;
    paralelo_serial_serdes #(.WIDTH(W)) dut (.clk(clk), .rstContador(rst), .bus(bus));
    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // model: frame position since reset, the word being sent, the last completed word
    int pos = 0;
    logic [W-1:0] cur = '0, done_word = '0, exp_salidas = '0;
    logic exp_salida = 1'b0, exp_valid = 1'b0, mdl_ok = 1'b0;
    always @(posedge clk) begin
        mdl_ok = 1'b1;
        if (rst) begin
            pos = 0;
            cur = '0;
            done_word = '0;
            exp_salida = 1'b0;
            exp_salidas = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = (pos == 0);
            if (pos == 0) begin
                exp_salidas = done_word;
                cur = bus.entradas;
                done_word = cur;
            end
            exp_salida = cur[W-1-pos];
            pos = (pos + 1) % W;
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("salida", W'(bus.salida), W'(exp_salida));
            chk("salidas", bus.salidas, exp_salidas);
            chk("salidasValidas", W'(bus.salidasValidas), W'(exp_valid));
        end
    end

    logic [W-1:0] pats [5] = '{10'b1010010101, 10'b0000000001, 10'b1111111110,
                               10'b0111111111, 10'b1000000000};
    logic [W-1:0] w1 = 10'b1100101100;
    logic [W-1:0] seq [3] = '{10'b1111100000, 10'b0000011111, 10'b1100101100};

    initial begin
        bus.entradas = '0;
        for (int i = 0; i < 14; i++) begin
            bus.entradas = pats[i % 5];
            @(negedge clk);
            chk("rst_salida", W'(bus.salida), '0);
            chk("rst_salidas", bus.salidas, '0);
            chk("rst_valid", W'(bus.salidasValidas), '0);
        end
        rst = 1'b0;
        bus.entradas = w1;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk($sformatf("single_bit%0d", k), W'(bus.salida), W'(w1[W-1-k]));
        end
        @(negedge clk);
        chk("single_word", bus.salidas, 10'b1100101100);
        chk("single_valid", W'(bus.salidasValidas), 10'd1);
        for (int j = 0; j < 3; j++) begin
            bus.entradas = seq[j];
            repeat (W) @(negedge clk);
            chk($sformatf("b2b_prev%0d", j), bus.salidas, j == 0 ? w1 : seq[j-1]);
        end
        bus.entradas = '0;
        repeat (W) @(negedge clk);
        chk("b2b_last", bus.salidas, 10'b1100101100);
        bus.entradas = 10'b0000000001;
        repeat (W) @(negedge clk);
        repeat (4) @(negedge clk);
        bus.entradas = 10'b1000000000;
        repeat (6) @(negedge clk);
        chk("midchg_cur", bus.salidas, 10'b0000000001);
        repeat (W) @(negedge clk);
        chk("midchg_next", bus.salidas, 10'b1000000000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_salida", W'(bus.salida), '0);
        chk("midrst_salidas", bus.salidas, '0);
        chk("midrst_valid", W'(bus.salidasValidas), '0);
        rst = 1'b0;
        bus.entradas = 10'b0111111111;
        @(negedge clk);
        chk("restart_first", bus.salidas, '0);
        chk("restart_first_valid", W'(bus.salidasValidas), 10'd1);
        repeat (W) @(negedge clk);
        chk("restart_word", bus.salidas, 10'b0111111111);
        chk("restart_valid", W'(bus.salidasValidas), 10'd1);
        @(negedge clk);
        chk("restart_valid_drop", W'(bus.salidasValidas), '0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/paralelo_serial_serdes.md
# paralelo_serial_serdes

10-bit parallel-to-serial transmitter and serial-to-parallel receiver pair sharing one clock and one counter reset. Link-layer test block: the transmitter shifts a 10-bit word out one bit per clock, MSB first; the receiver rebuilds it. Both halves have framing counters that are aligned by the common reset, so no sync pattern is needed. In the system, `salida` connects to `entrada` directly or through the synthesized netlist of the transmitter.

## Interface
Parameters:
- `WIDTH`, 10, word width in bits. The frame length is WIDTH clocks.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rstContador`  in  1  synchronous, active-high reset for both frame counters and all registers.
- `entradas`  in  WIDTH  transmit word. Sampled only at a frame start.
- `salida`  out  1  registered serial output, MSB first.
- `entrada`  in  1  serial input, normally connected to `salida`.
- `salidas`  out  WIDTH  registered received word.
- `salidasValidas`  out  1  one-cycle pulse, high during the cycle after `salidas` is updated.

## Operation
- Transmitter state:
  - counter `cntTx` runs 0..WIDTH-1 and wraps to 0.
  - word register `palabraTx`.
- Transmitter, each rising edge when not in reset:
  - If `cntTx==0`: `palabraTx <= entradas` and `salida <= entradas[WIDTH-1]`.
  - Otherwise: `salida <= palabraTx[WIDTH-1-cntTx]`.
  - `cntTx` increments and wraps from WIDTH-1 to 0.
- Receiver state:
  - counter `cntRx`, same sequence as `cntTx` and equal to it at every cycle.
  - shift register `sh`.
- Receiver, each rising edge when not in reset:
  - `sh <= {sh[WIDTH-2:0], entrada}`.
  - If `cntRx==0`: `salidas <= {sh[WIDTH-2:0], entrada}` and `salidasValidas <= 1`.
  - Otherwise: `salidasValidas <= 0`.
- Registered `salida` adds one cycle of delay. As a result, the bit the receiver samples at `cntRx==0` is bit 0 of the previous frame, which completes that word.
- Reset (`rstContador==1` at an edge):
  - counters, `palabraTx`, `sh`, `salida`, `salidas` and `salidasValidas` all go to 0.
  - Reset applied mid-frame aborts the frame. No partial word is emitted.
- First frame after reset: the first `cntRx==0` edge transfers the all-zero `sh`, so `salidas` stays 0 and `salidasValidas` pulses once.
- `entradas` changes while `cntTx!=0` have no effect until the next frame start.

## Timing
- Edge 0 is the first rising edge with `rstContador==0`. At edge 0 both counters are 0, so `entradas` is captured there.
- After edge k (k=0..WIDTH-1), `salida` holds bit WIDTH-1-k of the captured word.
- The word captured at edge E appears on `salidas` after edge E+WIDTH, which is also the next capture edge. Parallel-to-parallel latency is WIDTH clocks (10).
- Throughput: one word per WIDTH clocks, back-to-back, with no idle bits.
- Reset deassertion takes effect at the first edge with `rstContador` low. Framing restarts at `cnt=0` on that edge.

## Structure
- Shared package `serdes_pkg` holds:
  - `WIDTH` default (10).
  - `CNT_W = $clog2(WIDTH)`.
  - counter typedef `cnt_t`.
- One sub-module is natural: `serdes_frame_counter`, a wrapping counter with a synchronous clear. It is instantiated once in each half.
- Transmitter and receiver logic stay in the top. They must remain separable so the transmitter can be synthesized on its own and still drive the receiver.

## Test plan
Clock period 100 ns for all scenarios.
- **Reset hold:** `rstContador=1` for 14 cycles while `entradas` steps through 1010010101, 0000000001, 1111111110, 0111111111, 1000000000 -> `salida=0`, `salidas=0`, `salidasValidas=0` throughout.
- **Single word:** release reset with `entradas=1100101100` held.
  - `salida` after edges 0..9 = 1,1,0,0,1,0,1,1,0,0.
  - `salidas=1100101100` after edge 10, with a `salidasValidas` pulse.
- **Back-to-back words:** `entradas` = 1111100000, then 0000011111, then 1100101100, each changed right after a frame start.
  - `salidas` updates to each word exactly 10 cycles after it is captured.
  - No intermediate values appear.
- **Mid-frame change:** `entradas` goes from 0000000001 to 1000000000 at `cntTx=5` -> the current frame still serializes 0000000001, and the next frame serializes 1000000000.
- **Mid-frame reset:** assert reset at `cntTx=4` for one cycle.
  - All outputs read 0 after that edge.
  - Framing restarts and the next word is received correctly 10 cycles after release.
- **Synthesized transmitter:** drive the receiver from the synthesized transmitter netlist -> `salidas` is identical to the behavioural path on every cycle of the scenarios above.
